// File: rtl/ga23_pkg.sv
// Shared GA23 SDRAM read-path definitions: arbiter state encoding, bus widths
// common to the layer, arbiter and SDRAM-mux code, and a small pointer helper.
package ga23_pkg;

    localparam int unsigned GA23_SDR_ADDR_W = 22;
    localparam int unsigned GA23_SDR_DATA_W = 32;
    localparam int unsigned GA23_ARB_LAYERS = 3;
    localparam int unsigned GA23_ARB_CNT_W  = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } ga23_arb_state_t;

    // Increment modulo n (round-robin pointer advance).
    function automatic int unsigned ga23_wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/ga23_sdr_arbiter_if.sv
// Layer-side and SDRAM-side signals of the GA23 row-read arbiter.
//   lyr_req/lyr_addr   per-layer request pulse and packed row addresses
//   lyr_data/lyr_rdy   shared returned row word and per-layer ready pulse
//   ram_addr/ram_req   request to the SDRAM controller graphics read channel
//   ram_data/ram_rdy   read data and its valid pulse from the controller
//   timeout_err        sticky transaction-abandoned flag
// slave: the arbiter's view. master: the environment (layers + controller).
interface ga23_sdr_arbiter_if
    import ga23_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = GA23_ARB_LAYERS,
    parameter int unsigned ADDR_W     = GA23_SDR_ADDR_W,
    parameter int unsigned DATA_W     = GA23_SDR_DATA_W
) ();

    logic [NUM_LAYERS-1:0]        lyr_req;
    logic [NUM_LAYERS*ADDR_W-1:0] lyr_addr;
    logic [DATA_W-1:0]            lyr_data;
    logic [NUM_LAYERS-1:0]        lyr_rdy;
    logic [ADDR_W-1:0]            ram_addr;
    logic                         ram_req;
    logic [DATA_W-1:0]            ram_data;
    logic                         ram_rdy;
    logic                         timeout_err;

    modport slave (
        input  lyr_req, lyr_addr, ram_data, ram_rdy,
        output lyr_data, lyr_rdy, ram_addr, ram_req, timeout_err
    );

    modport master (
        output lyr_req, lyr_addr, ram_data, ram_rdy,
        input  lyr_data, lyr_rdy, ram_addr, ram_req, timeout_err
    );

endinterface

// File: rtl/ga23_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of pend_i at or
// after ptr_i, wrapping modulo N.
//   pend_i   pending request vector
//   ptr_i    highest-priority index this cycle
//   valid_o  any request pending
//   idx_o    selected index (0 when nothing pending)
module ga23_rr_pick
    import ga23_pkg::*;
#(
    parameter int unsigned N     = GA23_ARB_LAYERS,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pend_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic        found;
    int unsigned j;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && pend_i[IDX_W'(j)]) begin
                found = 1'b1;
                idx_o = IDX_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// Shares one SDRAM tile-row read port between the GA23 tilemap layers.
// Each layer's request pulse is latched into a one-deep pending entry; a
// round-robin FSM issues one SDRAM read at a time and returns the row word
// with a one-cycle per-layer ready pulse. Unanswered reads are abandoned
// after TIMEOUT cycles and flagged on a sticky error output.
//   clk      system clock, posedge
//   reset_n  asynchronous active-low reset
//   bus      layer and SDRAM-controller signals (slave modport)
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = GA23_ARB_LAYERS,
    parameter int unsigned ADDR_W     = GA23_SDR_ADDR_W,
    parameter int unsigned DATA_W     = GA23_SDR_DATA_W,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ga23_sdr_arbiter_if.slave    bus
);

    localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned CNT_W = GA23_ARB_CNT_W;

    // Pending entries
    logic [NUM_LAYERS-1:0] pend_q;
    logic [ADDR_W-1:0]     addr_q [NUM_LAYERS];

    // FSM and output registers
    ga23_arb_state_t       state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic                  ram_req_q, ram_req_d;
    logic [NUM_LAYERS-1:0] lyr_rdy_q, lyr_rdy_d;
    logic [DATA_W-1:0]     lyr_data_q, lyr_data_d;
    logic                  timeout_q, timeout_d;

    logic                  pick_valid_c;
    logic [IDX_W-1:0]      pick_idx_c;
    logic                  grant_c;
    logic [IDX_W-1:0]      ptr_next_c;

    ga23_rr_pick #(
        .N     (NUM_LAYERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid_c),
        .idx_o   (pick_idx_c)
    );

    assign ptr_next_c = IDX_W'(ga23_wrap_inc(32'(gnt_q), NUM_LAYERS));

    // Request capture; a new pulse beats the grant clear so a re-request on
    // the grant edge stays pending with its new address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (bus.lyr_req[i]) begin
                    pend_q[i] <= 1'b1;
                    addr_q[i] <= bus.lyr_addr[i*ADDR_W +: ADDR_W];
                end else if (grant_c && (pick_idx_c == IDX_W'(i))) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_req_q  <= 1'b0;
            lyr_rdy_q  <= '0;
            lyr_data_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_req_q  <= ram_req_d;
            lyr_rdy_q  <= lyr_rdy_d;
            lyr_data_q <= lyr_data_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_req_d  = 1'b0;
        lyr_rdy_d  = '0;
        lyr_data_d = lyr_data_q;
        timeout_d  = timeout_q;
        grant_c    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // Grant from registered pend only; ram_rdy is ignored here.
                if (pick_valid_c) begin
                    grant_c    = 1'b1;
                    gnt_d      = pick_idx_c;
                    ram_addr_d = addr_q[pick_idx_c];
                    ram_req_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus.ram_rdy) begin
                    lyr_data_d        = bus.ram_data;
                    lyr_rdy_d[gnt_q]  = 1'b1;
                    ptr_d             = ptr_next_c;
                    state_d           = ARB_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon; the layer's pending entry is not restored.
                    timeout_d = 1'b1;
                    ptr_d     = ptr_next_c;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_req     = ram_req_q;
    assign bus.lyr_rdy     = lyr_rdy_q;
    assign bus.lyr_data    = lyr_data_q;
    assign bus.timeout_err = timeout_q;

endmodule
